// File: rtl/mvm_if.sv
// Handshake and shared memory bus of the matrix-vector engine.
// The slave modport is the engine side; the master side is the host plus the ROM/SRAM.
interface mvm_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              start;
    logic [1:0]        mode;
    logic [3:0]        shift;
    logic              busy;
    logic              done;
    logic [1:0]        csb;
    logic              web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] dinx;
    logic [DATA_W-1:0] dinw;

    modport master (
        output start, mode, shift, dinx, dinw,
        input  busy, done, csb, web, addr, dout
    );

    modport slave (
        input  start, mode, shift, dinx, dinw,
        output busy, done, csb, web, addr, dout
    );
endinterface

// File: rtl/mvm_engine.sv
// Parametrised matrix-vector engine: y = post(W*x + b).
// W and b come from ROM, x from SRAM, and y is written back to SRAM.
module mvm_engine #(
    parameter int DATA_W    = 8,
    parameter int N         = 8,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = 20,
    parameter int BIAS_BASE = 64,
    parameter int X_BASE    = 0,
    parameter int OUT_BASE  = 8
) (
    input logic  clk,
    input logic  rst,
    mvm_if.slave bus
);
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_N  = CW'(N);
    localparam logic [CW-1:0] CNT_B  = CW'(N + 1);
    localparam logic [CW-1:0] ROW_L  = CW'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_ROW, S_WRITE, S_DONE} state_t;

    state_t                    state, state_n;
    logic [CW-1:0]             cnt, cnt_n, row, row_n;
    logic [1:0]                mode_q, mode_n;
    logic [3:0]                shift_q, shift_n;
    logic signed [ACC_W-1:0]   acc, acc_n;
    logic signed [DATA_W-1:0]  xr [N];
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [2*DATA_W-1:0] prod;

    logic [1:0]        csb_q, csb_n;
    logic              web_q, web_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] dout_q, dout_n;
    logic              busy_q, busy_n, done_q, done_n;

    assign bus.csb  = csb_q;
    assign bus.web  = web_q;
    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    function automatic logic [DATA_W-1:0] post(input logic signed [ACC_W-1:0] a,
                                               input logic [1:0] m, input logic [3:0] s);
        logic signed [ACC_W-1:0] r;
        r = a >>> s;
        if (m[0] && r < 0) r = '0;
        if (m[1]) begin
            if (r > SAT_MAX) r = SAT_MAX;
            else if (r < SAT_MIN) r = SAT_MIN;
        end
        return r[DATA_W-1:0];
    endfunction

    // Weight returned in ROW cycle c pairs with x[c-1].
    always_comb begin
        x_cur = '0;
        for (int unsigned j = 0; j < N; j++)
            if (cnt == CW'(j + 1)) x_cur = xr[j];
        prod = $signed(bus.dinw) * x_cur;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        mode_n  = mode_q;
        shift_n = shift_q;
        acc_n   = acc;
        case (state)
            S_IDLE: if (bus.start) begin
                state_n = S_LOAD_X;
                cnt_n   = '0;
                mode_n  = bus.mode;
                shift_n = bus.shift;
            end
            S_LOAD_X: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_N) begin
                    state_n = S_ROW;
                    cnt_n   = '0;
                    row_n   = '0;
                end
            end
            S_ROW: begin
                if (cnt == '0)         acc_n = '0;
                else if (cnt <= CNT_N) acc_n = acc + ACC_W'(prod);
                else                   acc_n = acc + ACC_W'($signed(bus.dinw));
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_B) begin
                    state_n = S_WRITE;
                    cnt_n   = '0;
                end
            end
            S_WRITE: begin
                cnt_n = '0;
                if (row == ROW_L) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_ROW;
                    row_n   = row + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        csb_n  = 2'b11;
        web_n  = 1'b1;
        addr_n = '0;
        dout_n = '0;
        busy_n = 1'b0;
        done_n = 1'b0;
        case (state_n)
            S_LOAD_X: begin
                busy_n = 1'b1;
                if (cnt_n < CNT_N) begin
                    csb_n  = 2'b10;
                    addr_n = ADDR_W'(X_BASE + int'(cnt_n));
                end
            end
            S_ROW: begin
                busy_n = 1'b1;
                csb_n  = 2'b01;
                if (cnt_n < CNT_N) addr_n = ADDR_W'(int'(row_n) * N + int'(cnt_n));
                else               addr_n = ADDR_W'(BIAS_BASE + int'(row_n));
            end
            S_WRITE: begin
                busy_n = 1'b1;
                csb_n  = 2'b10;
                web_n  = 1'b0;
                addr_n = ADDR_W'(OUT_BASE + int'(row_n));
                dout_n = post(acc_n, mode_q, shift_q);
            end
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            row     <= '0;
            mode_q  <= '0;
            shift_q <= '0;
            acc     <= '0;
            for (int unsigned j = 0; j < N; j++) xr[j] <= '0;
            csb_q   <= 2'b11;
            web_q   <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row     <= row_n;
            mode_q  <= mode_n;
            shift_q <= shift_n;
            acc     <= acc_n;
            if (state == S_LOAD_X)
                for (int unsigned j = 0; j < N; j++)
                    if (cnt == CW'(j + 1)) xr[j] <= $signed(bus.dinx);
            csb_q   <= csb_n;
            web_q   <= web_n;
            addr_q  <= addr_n;
            dout_q  <= dout_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end
endmodule

// File: tb/tb_mvm_engine.sv
// Scoreboard bench for mvm_engine: two instances (separate and in-place output),
// behavioural ROM/SRAM with one-cycle read latency.
module tb_mvm_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_r = 1'b0;
    int         sel     = 0;
    logic [1:0] mode_r  = 2'b00;
    logic [3:0] shift_r = 4'd0;
    int         checks  = 0;
    int         failures = 0;

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    logic [7:0] rom   [128];
    logic [7:0] sram0 [128];
    logic [7:0] sram1 [128];

    mvm_if #(.DATA_W(8), .ADDR_W(7)) b0 ();
    mvm_if #(.DATA_W(8), .ADDR_W(7)) b1 ();

    mvm_engine #(.DATA_W(8), .N(8), .ADDR_W(7), .ACC_W(20), .BIAS_BASE(64),
                 .X_BASE(0), .OUT_BASE(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mvm_engine #(.DATA_W(8), .N(8), .ADDR_W(7), .ACC_W(20), .BIAS_BASE(64),
                 .X_BASE(0), .OUT_BASE(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

    assign b0.start = start_r && (sel == 0);
    assign b1.start = start_r && (sel == 1);
    assign b0.mode  = mode_r;
    assign b1.mode  = mode_r;
    assign b0.shift = shift_r;
    assign b1.shift = shift_r;

    always @(posedge clk) begin
        if (!b0.csb[1]) b0.dinw <= rom[b0.addr];
        if (!b0.csb[0]) begin
            if (b0.web) b0.dinx <= sram0[b0.addr];
            else        sram0[b0.addr] = b0.dout;
        end
        if (!b1.csb[1]) b1.dinw <= rom[b1.addr];
        if (!b1.csb[0]) begin
            if (b1.web) b1.dinx <= sram1[b1.addr];
            else        sram1[b1.addr] = b1.dout;
        end
    end

    logic [1:0] mon_csb;
    logic       mon_web, mon_busy, mon_done;
    logic [6:0] mon_addr;
    logic [7:0] mon_dout;
    assign mon_csb  = (sel == 1) ? b1.csb  : b0.csb;
    assign mon_web  = (sel == 1) ? b1.web  : b0.web;
    assign mon_busy = (sel == 1) ? b1.busy : b0.busy;
    assign mon_done = (sel == 1) ? b1.done : b0.done;
    assign mon_addr = (sel == 1) ? b1.addr : b0.addr;
    assign mon_dout = (sel == 1) ? b1.dout : b0.dout;

    task automatic setup(input int wd, input int wo, input int bv, input int x0, input int xs);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) rom[i*8+j] = 8'((i == j) ? wd : wo);
            rom[64+i] = 8'(bv);
            sram0[i]  = 8'(x0 + xs * i);
            sram1[i]  = 8'(x0 + xs * i);
        end
    endtask

    task automatic push_expected(input int s, input logic [1:0] md, input logic [3:0] sh);
        longint acc, r;
        logic [7:0] xv;
        wr_t e;
        for (int i = 0; i < 8; i++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                xv  = (s == 1) ? sram1[j] : sram0[j];
                acc = acc + longint'($signed(rom[i*8+j])) * longint'($signed(xv));
            end
            acc = acc + longint'($signed(rom[64+i]));
            r = acc >>> sh;
            if (md[0] && r < 0) r = 0;
            if (md[1]) begin
                if (r > 127) r = 127;
                if (r < -128) r = -128;
            end
            e.d = r[7:0];
            e.a = 7'(((s == 1) ? 0 : 8) + i);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_op(input int s, input logic [1:0] md, input logic [3:0] sh,
                          input int pulse_at, input int rst_at, input string tag);
        int  lat = 0;
        int  nwr = 0;
        int  late_wr = 0;
        wr_t e;
        push_expected(s, md, sh);
        sel = s; mode_r = md; shift_r = sh;
        @(posedge clk); #1 start_r = 1'b1;
        @(posedge clk); #1 start_r = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == pulse_at)     start_r = 1'b1;
            if (k == pulse_at + 1) start_r = 1'b0;
            if (mon_csb == 2'b10 && mon_web == 1'b0) begin
                if (rst_at > 0 && k > rst_at) late_wr++;
                else begin
                    nwr++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s unexpected write addr=%0d data=%02h", tag, mon_addr, mon_dout);
                    end else begin
                        e = exp_q.pop_front();
                        if ({mon_addr, mon_dout} !== {e.a, e.d}) begin
                            failures++;
                            $display("FAIL %s write got addr=%0d data=%02h want addr=%0d data=%02h",
                                     tag, mon_addr, mon_dout, e.a, e.d);
                        end
                    end
                end
            end
            if (rst_at > 0) begin
                if (k == rst_at) rst = 1'b1;
                if (k == rst_at + 1) begin
                    checks++;
                    if ({mon_csb, mon_busy, mon_web, mon_done} !== {2'b11, 1'b0, 1'b1, 1'b0}) begin
                        failures++;
                        $display("FAIL %s after-reset csb=%b busy=%b web=%b done=%b want 11/0/1/0",
                                 tag, mon_csb, mon_busy, mon_web, mon_done);
                    end
                end
                if (k == rst_at + 5) begin
                    rst = 1'b0;
                    checks++;
                    if (late_wr !== 0) begin
                        failures++;
                        $display("FAIL %s writes after reset got %0d want 0", tag, late_wr);
                    end
                    exp_q.delete();
                    return;
                end
            end else if (mon_done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 97) begin
            failures++;
            $display("FAIL %s latency got %0d want 97", tag, lat);
        end
        checks++;
        if (nwr !== 8) begin
            failures++;
            $display("FAIL %s write count got %0d want 8", tag, nwr);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        checks++;
        if ({b0.csb, b0.web, b0.addr, b0.dout, b0.busy, b0.done} !== {2'b11, 1'b1, 7'd0, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_u0 got csb=%b web=%b addr=%0d dout=%0d busy=%b done=%b want 11/1/0/0/0/0",
                     b0.csb, b0.web, b0.addr, b0.dout, b0.busy, b0.done);
        end
        checks++;
        if ({b1.csb, b1.web, b1.addr, b1.dout, b1.busy, b1.done} !== {2'b11, 1'b1, 7'd0, 8'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_u1 got csb=%b web=%b addr=%0d dout=%0d busy=%b done=%b want 11/1/0/0/0/0",
                     b1.csb, b1.web, b1.addr, b1.dout, b1.busy, b1.done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({b0.csb, b0.busy, b0.done} !== {2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL idle_u0 got csb=%b busy=%b done=%b want 11/0/0", b0.csb, b0.busy, b0.done);
        end
    endtask

    task automatic test_identity();
        setup(1, 0, 0, 1, 1);
        run_op(0, 2'b00, 4'd0, 0, 0, "identity");
    endtask

    task automatic test_saturate();
        setup(127, 127, 0, 127, 0);
        run_op(0, 2'b10, 4'd0, 0, 0, "sat_on");
        run_op(0, 2'b00, 4'd0, 0, 0, "sat_off");
    endtask

    task automatic test_negative();
        setup(-1, 0, 0, 1, 1);
        run_op(0, 2'b00, 4'd0, 0, 0, "neg_plain");
        run_op(0, 2'b01, 4'd0, 0, 0, "neg_relu");
    endtask

    task automatic test_shift();
        setup(1, 0, 0, -3, 0);
        run_op(0, 2'b00, 4'd1, 0, 0, "shift_floor");
        setup(64, 0, 0, 4, 0);
        run_op(0, 2'b00, 4'd6, 0, 0, "shift_six");
    endtask

    task automatic test_in_place();
        setup(2, 0, 1, 1, 1);
        run_op(1, 2'b00, 4'd0, 50, 0, "in_place");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sram1[i] !== 8'(2 * i + 3)) begin
                failures++;
                $display("FAIL in_place_mem[%0d] got %0d want %0d", i, sram1[i], 2 * i + 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        setup(1, 0, 0, 1, 1);
        run_op(0, 2'b00, 4'd0, 0, 40, "rst_mid");
        run_op(0, 2'b00, 4'd0, 0, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_saturate();
        test_negative();
        test_shift();
        test_in_place();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mvm_engine.md
Name: mvm_engine

Overview:
- Parametrised successor to the fixed 8x8 matrix-vector processor.
- Computes y = post(W·x + b) for an N×N signed matrix W and an N-entry vector x; post() is a selectable shift/ReLU/saturate stage.
- W and b are read from the single-port ROM, x from the single-port SRAM; y is written back to SRAM.
- Adds start/done/busy handshake, runtime mode and shift, and in-place output.

Parameters:
- DATA_W, 8, element width (signed two's complement) for W, b, x, y.
- N, 8, matrix dimension (2..16).
- ADDR_W, 7, shared memory address width.
- ACC_W, 20, accumulator width; must be >= 2*DATA_W+clog2(N)+1.
- BIAS_BASE, 64, ROM address of b[0]; W[i][j] sits at ROM address i*N+j.
- X_BASE, 0, SRAM address of x[0].
- OUT_BASE, 8, SRAM address of y[0]; may equal X_BASE.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  2  [0]=ReLU enable, [1]=saturate enable; latched at start.
- shift  in  4  arithmetic right-shift amount; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse on completion.
- csb  out  2  active-low chip selects: [1]=ROM, [0]=SRAM.
- web  out  1  active-low SRAM write enable.
- addr  out  ADDR_W  shared address; SRAM uses the low bits.
- dout  out  DATA_W  SRAM write data.
- dinx  in  DATA_W  SRAM read data.
- dinw  in  DATA_W  ROM read data.

Behaviour:
- All outputs are registered.
- Reset and IDLE values: csb=2'b11, web=1, addr=0, dout=0, busy=0, done=0. Accumulator, counters and x-register-file are cleared.
- Memory read latency: address issued in cycle k with csb low; data is valid on dinx/dinw during k+1 and is captured at the end of k+1.
- States:
  - IDLE: start=1 latches mode and shift, goes to LOAD_X.
  - LOAD_X (N+1 cycles): issues SRAM reads X_BASE..X_BASE+N-1 with csb=2'b10, web=1. Captures x[j] into the internal register file one cycle behind the issue.
  - ROW i (N+2 cycles, csb=2'b01):
    - Issues W[i][0..N-1], then BIAS_BASE+i.
    - acc is cleared at row entry.
    - acc += sext(W)*sext(x[j]) for each returned weight, then acc += sext(b[i]).
  - WRITE i (1 cycle): csb=2'b10, web=0, addr=OUT_BASE+i, dout=post(acc). Then i+1 goes to ROW, or after i=N-1 goes to DONE.
  - DONE (1 cycle): done=1, busy=0, returns to IDLE.
- post(acc):
  - r = acc >>> shift (arithmetic, floor).
  - If mode[0] and r<0, r=0.
  - If mode[1], clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; else take the low DATA_W bits.
- Latency: done is high exactly (N+1)+N·(N+3) cycles after the edge that accepted start (97 for N=8).
- Because x is fully preloaded, OUT_BASE overlapping x is safe (in-place).
- start while busy is ignored. start held high in DONE/IDLE begins a new run the cycle after DONE.
- rst mid-operation: at the next edge all outputs take reset values; no further memory access or write occurs.
- Accumulator wrap is impossible by the ACC_W rule; no overflow flag.

Test Plan:
- W=I, b=0, x=1..8, mode=00, shift=0:
  - SRAM[8..15]=1..8.
  - done at cycle 97 after start; exactly 8 writes seen.
- W=all 127, x=all 127, b=0, shift=0, acc=129032:
  - mode=10 -> every y=127.
  - mode=00 -> every y=8 (low byte).
- W=-I, x=1..8, b=0:
  - mode=00 -> y=0xFF..0xF8.
  - mode=01 -> y all 0.
- W=I, x=-3, b=0, shift=1, mode=00 -> y=-2 (0xFE). Same setup with x=4, W=64·I, shift=6 -> y=4.
- OUT_BASE=X_BASE=0, W=2·I, b=1, x=1..8 -> SRAM[0..7]=3,5,...,17. start pulsed again at cycle 50 is ignored; done still at 97.
- rst asserted at cycle 40 of a run:
  - Next edge: csb=11, busy=0; no further writes.
  - A fresh start then completes normally in 97 cycles with correct y.
